// File: rtl/regfile_sb.sv
`timescale 1ns/1ps
// Register file with per-register pending-producer scoreboard, same-cycle write
// bypass, and a one-register-per-cycle clear sweep controlled by a small FSM.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWr,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] regA,
    input  logic [ADDR_W-1:0] regB,
    output logic [DATA_W-1:0] read_dataA,
    output logic [DATA_W-1:0] read_dataB,
    input  logic              set_busy,
    input  logic [ADDR_W-1:0] busy_reg,
    output logic              busyA,
    output logic              busyB,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_done
);
    localparam int NUM_REGS = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(ZERO_REG);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(NUM_REGS-1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic                clr_busy_q, clr_busy_d;
    logic                clr_done_q, clr_done_d;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic                wr_fire, wr_en;

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Writes (and their bypass / busy-clear side effects) only exist in IDLE.
    assign wr_fire = (state_q == IDLE) && RegWr;
    assign wr_en   = wr_fire && !is_zero(write_reg);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        regs_d     = regs_q;
        busy_d     = busy_q;
        clr_busy_d = 1'b0;
        clr_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_en) regs_d[write_reg] = write_data;
                if (wr_fire) busy_d[write_reg] = 1'b0;
                // set after clear so a same-cycle producer keeps the bit set
                if (set_busy && !is_zero(busy_reg)) busy_d[busy_reg] = 1'b1;
                if (clr_start) begin
                    state_d    = CLEAR;
                    busy_d     = '0;
                    idx_d      = FIRST;
                    clr_busy_d = 1'b1;
                end
            end
            CLEAR: begin
                regs_d[idx_q] = '0;
                if (idx_q == LAST) begin
                    state_d    = IDLE;
                    idx_d      = FIRST;
                    clr_done_d = 1'b1;
                end else begin
                    idx_d      = idx_q + 1'b1;
                    clr_busy_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (ZERO_REG != 0) begin
            regs_d[0] = '0;
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= FIRST;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b0;
            busy_q     <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            clr_busy_q <= clr_busy_d;
            clr_done_q <= clr_done_d;
            busy_q     <= busy_d;
            regs_q     <= regs_d;
        end
    end

    always_comb begin
        read_dataA = regs_q[regA];
        if (wr_en && (write_reg == regA)) read_dataA = write_data;
        if (is_zero(regA)) read_dataA = '0;
        read_dataB = regs_q[regB];
        if (wr_en && (write_reg == regB)) read_dataB = write_data;
        if (is_zero(regB)) read_dataB = '0;
    end

    assign busyA = busy_q[regA] && !(wr_fire && (write_reg == regA)) && !is_zero(regA);
    assign busyB = busy_q[regB] && !(wr_fire && (write_reg == regB)) && !is_zero(regB);

    assign clr_busy = clr_busy_q;
    assign clr_done = clr_done_q;
endmodule
